// File: rtl/calc_op_sched.sv
// Sequences one calculator operation at a time: latch the command, start one unit,
// wait for its done (or time out), then hold the result under a valid/ready handshake.
module calc_op_sched #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        parser_done,
    input  logic [1:0]  op,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    output logic [15:0] op_src1,
    output logic [15:0] op_src2,
    output logic [3:0]  unit_start,
    input  logic [3:0]  unit_done,
    input  logic [31:0] add_res,
    input  logic [31:0] sub_res,
    input  logic [31:0] mul_res,
    input  logic [31:0] div_res,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_err,
    input  logic        res_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t          state;
    logic [1:0]      op_q;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     sel_res;

    always_comb begin
        sel_res = add_res;
        case (op_q)
            2'd1:    sel_res = sub_res;
            2'd2:    sel_res = mul_res;
            2'd3:    sel_res = div_res;
            default: sel_res = add_res;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            op_q       <= 2'd0;
            op_src1    <= 16'd0;
            op_src2    <= 16'd0;
            unit_start <= 4'd0;
            to_cnt     <= '0;
            res_valid  <= 1'b0;
            res_data   <= 32'd0;
            res_err    <= 1'b0;
        end else begin
            unit_start <= 4'd0;
            case (state)
                IDLE: begin
                    if (parser_done) begin
                        op_q    <= op;
                        op_src1 <= src1;
                        op_src2 <= src2;
                        // Divide-by-zero is answered here without starting the divider
                        if (op == 2'd3 && src2 == 16'd0) begin
                            state     <= HOLD;
                            res_valid <= 1'b1;
                            res_data  <= 32'd0;
                            res_err   <= 1'b1;
                        end else begin
                            state      <= LAUNCH;
                            unit_start <= 4'b0001 << op;
                        end
                    end
                end
                LAUNCH: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (unit_done[op_q]) begin
                        res_data  <= sel_res;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (to_cnt == TO_LIM) begin
                        res_data  <= 32'hFFFF_FFFF;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commands arriving while an operation is in flight are lost; count them
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            drop_cnt <= 8'd0;
        else if (parser_done && state != IDLE && drop_cnt != 8'd255)
            drop_cnt <= drop_cnt + 8'd1;
    end

endmodule
